alu_result_queue: RTL
=====================

# alu_result_queue

Downstream capture stage for the 16-bit ALU. Accepts each ALU result Z with its five flags (sign, zero, parity, carry, overflow) under a valid/ready handshake and buffers them in a small in-order FIFO. It presents the oldest entry to the consumer (register writeback or branch unit) and keeps sticky carry/overflow status.

## Interface
- WIDTH, 16, data width; matches ALU Z.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a result on Z/flags.
- in_ready  output  1  queue can accept; equals (count < DEPTH).
- Z  input  WIDTH  ALU result.
- sign, zero, parity, carry, overflow  input  1 each  ALU flags.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  WIDTH  head result.
- out_flags  output  5  head flags: [4]=overflow, [3]=carry, [2]=parity, [1]=zero, [0]=sign.
- count  output  $clog2(DEPTH)+1  occupancy.
- sticky_flags  output  2  [1]=overflow seen, [0]=carry seen.
- sticky_clr  input  1  clears sticky_flags.
- flag_err  output  1  sticky flag-consistency error (see Configuration).

## Operation
- Push: on an edge with in_valid && in_ready, store {Z, flags} at the write pointer. Increment wr_ptr modulo DEPTH.
- Pop: on an edge with out_valid && out_ready, increment rd_ptr modulo DEPTH.
- Count:
  - push only: +1.
  - pop only: -1.
  - both: unchanged, and both pointers advance.
  - neither: unchanged.
- Full (count == DEPTH): in_ready = 0. A push attempt is ignored and the producer must hold its data. A pop in that cycle still occurs.
- Empty (count == 0): out_valid = 0. out_data and out_flags hold their last values, which are don't-care. A push and a pop cannot occur in the same cycle when empty.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full versus empty is decided by count only.
- Ordering: strict FIFO. Data and flags of one entry are never split.
- Sticky flags:
  - On an accepted push, sticky_flags |= {overflow, carry}.
  - sticky_clr zeroes them on the next edge.
  - If sticky_clr coincides with an accepted push that carries a set flag, the set wins for that bit.
- No state machine beyond the pointers and count; the queue has no error state.

## Timing
- Reset (asynchronous, rst_n low), all cleared:
  - count, pointers, sticky_flags, flag_err = 0.
  - out_valid = 0, out_data = 0, out_flags = 0.
  - in_ready = 1 once reset is released.
- Storage is cleared on reset. Reset mid-operation discards all queued entries immediately; there is no drain.
- Latency: an entry pushed at edge k is visible on out_data/out_flags with out_valid = 1 after edge k (cycle k+1), with no fall-through in the same cycle.
- out_valid, out_data and out_flags are driven from registers or storage indexed by a registered pointer. There is no combinational path from in_* to out_*.
- in_ready depends only on the registered count; it has no combinational dependence on out_ready.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Configuration
- ALU_RESULT_QUEUE_CHECK_EN
  - Defined: on each accepted push, compare zero with (Z == 0) and sign with Z[WIDTH-1]. Any mismatch sets flag_err on the next edge. flag_err stays set until rst_n is asserted; sticky_clr does not clear it.
  - Undefined: the check logic is not compiled in, and flag_err is tied to 0.

## Test plan
- Reset then push A=8fff+8000: Z=0fff, carry=1, overflow=1, sign=0, zero=0, parity per ALU. Required: out_valid rises one cycle after the push, out_data=0fff, out_flags[4:3]=11, sticky_flags=11.
- With out_ready=0, push Z=0000 (zero=1, carry=1), then ffff (sign=1), then two more entries. Required: count reaches 4, in_ready=0, and a fifth push is ignored. Then hold out_ready=1: outputs appear in order 0000, ffff, … and count returns to 0.
- Sustained simultaneous push/pop for 10 cycles at count=2 across pointer wrap. Required: count stays 2 and the data order is preserved.
- Assert sticky_clr in the same cycle as a push with overflow=1, carry=0. Required: sticky_flags=10 after the edge. A later sticky_clr with no push gives 00.
- Assert rst_n low with 3 entries queued, mid-cycle. Required: out_valid=0, count=0, sticky_flags=0 immediately. After release, the first new push emerges in cycle k+1.
- With ALU_RESULT_QUEUE_CHECK_EN: push Z=0001 with zero=1. Required: flag_err=1 after the edge and held until reset. Without the macro: flag_err remains 0.

Source files
------------

// File: rtl/alu_result_queue_if.sv
// Handshake bundle between ALU producer, result queue and consumer.
// The queue takes the slave side; the producer/consumer pair drive master.
interface alu_result_queue_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Z;
    logic             sign;
    logic             zero;
    logic             parity;
    logic             carry;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_flags;

    modport master (
        output in_valid, Z, sign, zero, parity, carry, overflow,
        output out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, Z, sign, zero, parity, carry, overflow,
        input  out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/alu_result_queue.sv
// In-order FIFO of ALU results with flags and sticky carry/overflow status.
// Optional flag-consistency checker: define ALU_RESULT_QUEUE_CHECK_EN.
module alu_result_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_queue_if.slave    bus,
    output logic [CW-1:0]        count,
    output logic [1:0]           sticky_flags,
    input  logic                 sticky_clr,
    output logic                 flag_err
);
    localparam int EW = WIDTH + 5;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    sticky_q, sticky_d;
    logic          push, pop;
    logic [EW-1:0] entry;

    assign bus.in_ready  = (count_q < CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign entry = {bus.Z, bus.overflow, bus.carry,
                    bus.parity, bus.zero, bus.sign};

    // Head is read straight from storage at the registered read pointer.
    assign bus.out_data  = mem_q[rd_ptr_q][EW-1:5];
    assign bus.out_flags = mem_q[rd_ptr_q][4:0];

    assign count        = count_q;
    assign sticky_flags = sticky_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A set arriving with the clear wins for that bit.
    always_comb begin
        sticky_d = sticky_clr ? 2'b00 : sticky_q;
        if (push) sticky_d = sticky_d | {bus.overflow, bus.carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

`ifdef ALU_RESULT_QUEUE_CHECK_EN
    logic err_q, err_d;
    logic bad;

    assign bad = (bus.zero != (bus.Z == '0)) ||
                 (bus.sign != bus.Z[WIDTH-1]);

    always_comb begin
        err_d = err_q;
        if (push && bad) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign flag_err = err_q;
`else
    assign flag_err = 1'b0;
`endif
endmodule
